// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with a start/busy/done handshake and an optional iterative multiply.
// Build macro: define MULTALU_MUL_EN to compile in the MUL state and the unsigned multiply (opcode 1000).
module multicycle_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_SLT   = 4'b1010;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_XOR   = 4'b0110;
   localparam logic [3:0] OP_NOR   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1100;
   localparam logic [3:0] OP_SRL   = 4'b1101;
   localparam logic [3:0] OP_SRA   = 4'b1110;
`ifdef MULTALU_MUL_EN
   localparam logic [3:0] OP_MULTU = 4'b1000;
`endif

   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_lo;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] result_next;
   logic [WIDTH-1:0] result_hi_next;
   logic             zero_next;
   logic             done_next;

   assign shamt = b[SHW-1:0];
   assign diff  = a - b;

   // Single-cycle datapath; undefined opcodes (and multu when disabled) yield zero
   always_comb begin
      alu_lo = {WIDTH{1'b0}};
      case (alu_op)
         OP_ADD:  alu_lo = a + b;
         OP_SUB:  alu_lo = diff;
         OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
         OP_AND:  alu_lo = a & b;
         OP_OR:   alu_lo = a | b;
         OP_XOR:  alu_lo = a ^ b;
         OP_NOR:  alu_lo = ~(a | b);
         OP_SLL:  alu_lo = a << shamt;
         OP_SRL:  alu_lo = a >> shamt;
         OP_SRA:  alu_lo = $unsigned($signed(a) >>> shamt);
         default: alu_lo = {WIDTH{1'b0}};
      endcase
   end

`ifdef MULTALU_MUL_EN
   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

   localparam int            CW         = SHW + 1;
   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] COUNT_LAST = CW'(1);

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_next;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mcand_next;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_next;
   logic [2*WIDTH-1:0] step;
   logic [WIDTH:0]     partial;

   // Shift-add step: upper half accumulates, lower half shifts the multiplier out
   always_comb begin
      if (prod[0]) begin
         partial = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      end else begin
         partial = {1'b0, prod[2*WIDTH-1:WIDTH]};
      end
      step = {partial, prod[WIDTH-1:1]};
   end

   // Next-state and next-output logic
   always_comb begin
      state_next     = state;
      count_next     = count;
      mcand_next     = mcand;
      prod_next      = prod;
      result_next    = result;
      result_hi_next = result_hi;
      zero_next      = zero;
      done_next      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (alu_op == OP_MULTU) begin
                  state_next = MUL;
                  count_next = COUNT_INIT;
                  mcand_next = a;
                  prod_next  = {{WIDTH{1'b0}}, b};
               end else begin
                  result_next    = alu_lo;
                  result_hi_next = {WIDTH{1'b0}};
                  zero_next      = (alu_lo == {WIDTH{1'b0}});
                  done_next      = 1'b1;
               end
            end else begin
               state_next = IDLE;
            end
         end
         MUL: begin
            prod_next  = step;
            count_next = count - COUNT_LAST;
            if (count == COUNT_LAST) begin
               state_next     = IDLE;
               result_next    = step[WIDTH-1:0];
               result_hi_next = step[2*WIDTH-1:WIDTH];
               zero_next      = (step[WIDTH-1:0] == {WIDTH{1'b0}});
               done_next      = 1'b1;
            end else begin
               state_next = MUL;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = {CW{1'b0}};
         end
      endcase
   end

   // Multiplier state registers; reset discards any partial product
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= {CW{1'b0}};
         mcand <= {WIDTH{1'b0}};
         prod  <= {(2*WIDTH){1'b0}};
      end else begin
         state <= state_next;
         count <= count_next;
         mcand <= mcand_next;
         prod  <= prod_next;
      end
   end

   assign busy = (state == MUL);
`else
   // Next-output logic when only single-cycle operations exist
   always_comb begin
      result_next    = result;
      result_hi_next = result_hi;
      zero_next      = zero;
      done_next      = 1'b0;
      if (start) begin
         result_next    = alu_lo;
         result_hi_next = {WIDTH{1'b0}};
         zero_next      = (alu_lo == {WIDTH{1'b0}});
         done_next      = 1'b1;
      end else begin
         done_next = 1'b0;
      end
   end

   assign busy = 1'b0;
`endif

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result    <= {WIDTH{1'b0}};
         result_hi <= {WIDTH{1'b0}};
         zero      <= 1'b1;
         done      <= 1'b0;
      end else begin
         result    <= result_next;
         result_hi <= result_hi_next;
         zero      <= zero_next;
         done      <= done_next;
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: scoreboard queue of expected results popped on done.
// Follows MULTALU_MUL_EN to choose between multiply tests and disabled-multiply tests.
module tb_multicycle_alu;
   localparam int WIDTH = 32;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        z;
      string       name;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  alu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic [31:0] result_hi;
   logic        zero;
   logic        busy;
   logic        done;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t got;
   logic busy_seen = 1'b0;

   multicycle_alu #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .alu_op    (alu_op),
      .a         (a),
      .b         (b),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (busy === 1'b1) busy_seen <= 1'b1;
   end

   // Scoreboard: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: done=1 result=%h with no pending op", result);
         end else begin
            got = exp_q.pop_front();
            if (result !== got.lo || result_hi !== got.hi || zero !== got.z) begin
               failures++;
               $display("FAIL %s: got lo=%h hi=%h zero=%b, expected lo=%h hi=%h zero=%b",
                        got.name, result, result_hi, zero, got.lo, got.hi, got.z);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      exp_t        m;
      logic [31:0] d;
      d      = x - y;
      m.lo   = 32'd0;
      m.hi   = 32'd0;
      m.name = "random";
      case (op)
         4'b0000: m.lo = x + y;
         4'b0010: m.lo = d;
         4'b1010: m.lo = d[31] ? 32'd1 : 32'd0;
         4'b0100: m.lo = x & y;
         4'b0101: m.lo = x | y;
         4'b0110: m.lo = x ^ y;
         4'b0111: m.lo = ~(x | y);
         4'b1100: m.lo = x << y[4:0];
         4'b1101: m.lo = x >> y[4:0];
         4'b1110: m.lo = 32'($signed(x) >>> y[4:0]);
         default: m.lo = 32'd0;
      endcase
      m.z = (m.lo == 32'd0);
      return m;
   endfunction

   task automatic do_op(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic ez,
                        input string name);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle: done=%b busy=%b, expected 0 0", name, done, busy);
      end
      start  = 1'b1;
      alu_op = op;
      a      = xa;
      b      = xb;
      exp_q.push_back('{elo, ehi, ez, name});
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s_latency: done=%b one cycle after start, expected 1", name, done);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      start  = 1'b0;
      alu_op = 4'b0000;
      a      = 32'd0;
      b      = 32'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (result !== 32'd0 || result_hi !== 32'd0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: result=%h hi=%h zero=%b busy=%b done=%b, expected 0 0 1 0 0",
                  result, result_hi, zero, busy, done);
      end
      reset = 1'b0;
   endtask

   task automatic test_add_sub();
      do_op(4'b0000, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, "add_5_7");
      do_op(4'b0010, 32'd7, 32'd7, 32'd0, 32'd0, 1'b1, "sub_7_7");
      do_op(4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b1, "add_wrap");
      do_op(4'b0010, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, "sub_wrap");
   endtask

   task automatic test_logic();
      do_op(4'b1010, 32'd3, 32'd5, 32'd1, 32'd0, 1'b0, "slt_3_5");
      do_op(4'b1010, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 1'b0, "slt_m1_1");
      do_op(4'b1010, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1, "slt_5_3");
      do_op(4'b0111, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0, "nor_0_0");
      do_op(4'b0110, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 32'd0, 1'b0, "xor");
      do_op(4'b0100, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 32'd0, 1'b0, "and");
      do_op(4'b0101, 32'hF0F0F0F0, 32'h0000FFFF, 32'hF0F0FFFF, 32'd0, 1'b0, "or");
   endtask

   task automatic test_shifts();
      do_op(4'b1110, 32'h80000000, 32'd4, 32'hF8000000, 32'd0, 1'b0, "sra_4");
      do_op(4'b1101, 32'h80000000, 32'd4, 32'h08000000, 32'd0, 1'b0, "srl_4");
      do_op(4'b1100, 32'd1, 32'd31, 32'h80000000, 32'd0, 1'b0, "sll_31");
      do_op(4'b1100, 32'h12345678, 32'd0, 32'h12345678, 32'd0, 1'b0, "sll_0");
      do_op(4'b1101, 32'h12345678, 32'hFFFFFF00, 32'h12345678, 32'd0, 1'b0, "srl_hi_b_ignored");
   endtask

   task automatic test_undefined();
      logic [3:0] undef_ops [5] = '{4'b0001, 4'b0011, 4'b1001, 4'b1011, 4'b1111};
      for (int i = 0; i < 5; i++) begin
         do_op(undef_ops[i], 32'hDEADBEEF, 32'h12345678, 32'd0, 32'd0, 1'b1, "undefined_op");
      end
   endtask

   task automatic test_random();
      logic [3:0]  ops [10] = '{4'b0000, 4'b0010, 4'b1010, 4'b0100, 4'b0101,
                                4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110};
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      exp_t        m;
      for (int i = 0; i < 20; i++) begin
         op = ops[$urandom_range(0, 9)];
         x  = $urandom;
         y  = $urandom;
         m  = model(op, x, y);
         do_op(op, x, y, m.lo, m.hi, m.z, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         x      = 32'(i * 3 + 1);
         start  = 1'b1;
         alu_op = 4'b0000;
         a      = x;
         b      = 32'd100;
         exp_q.push_back('{x + 32'd100, 32'd0, 1'b0, "b2b_add"});
         @(negedge clk);
         checks++;
         if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: done=%b at op %0d, expected 1", done, i);
         end
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done_low: done=%b after last op, expected 0", done);
      end
   endtask

`ifdef MULTALU_MUL_EN
   task automatic test_multu();
      int busy_cycles;
      busy_cycles = 0;
      @(negedge clk);
      start  = 1'b1;
      alu_op = 4'b1000;
      a      = 32'hFFFFFFFF;
      b      = 32'd2;
      exp_q.push_back('{32'hFFFFFFFE, 32'h00000001, 1'b0, "multu"});
      for (int j = 0; j < WIDTH; j++) begin
         @(negedge clk);
         start = 1'b0;
         if (j == 4) begin
            start  = 1'b1;
            alu_op = 4'b0000;
            a      = 32'd1;
            b      = 32'd1;
         end
         if (busy === 1'b1) busy_cycles++;
         checks++;
         if (done !== 1'b0) begin
            failures++;
            $display("FAIL multu_early_done: done=%b at cycle %0d, expected 0", done, j);
         end
      end
      checks++;
      if (busy_cycles != WIDTH) begin
         failures++;
         $display("FAIL multu_busy_len: busy cycles=%0d, expected %0d", busy_cycles, WIDTH);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL multu_done: done=%b busy=%b at cycle %0d, expected 1 0", done, busy, WIDTH);
      end
      start  = 1'b1;
      alu_op = 4'b0000;
      a      = 32'd1;
      b      = 32'd1;
      exp_q.push_back('{32'd2, 32'd0, 1'b0, "add_in_done_cycle"});
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL accept_in_done_cycle: done=%b, expected 1", done);
      end
   endtask

   task automatic test_reset_mid_mul();
      @(negedge clk);
      start  = 1'b1;
      alu_op = 4'b1000;
      a      = 32'h0001_0003;
      b      = 32'h0002_0005;
      exp_q.push_back('{32'h000B_0000 + 32'h0000_000F, 32'h0000_0002, 1'b0, "multu_aborted"});
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (result !== 32'd0 || result_hi !== 32'd0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_mul: result=%h hi=%h zero=%b busy=%b done=%b, expected 0 0 1 0 0",
                  result, result_hi, zero, busy, done);
      end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      do_op(4'b0000, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, "add_after_reset");
   endtask
`else
   task automatic test_mul_disabled();
      do_op(4'b1000, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, "op1000_disabled");
      @(negedge clk);
      checks++;
      if (busy_seen !== 1'b0) begin
         failures++;
         $display("FAIL busy_never: busy observed=%b, expected 0", busy_seen);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_shifts();
      test_undefined();
      test_back_to_back();
`ifdef MULTALU_MUL_EN
      test_multu();
      test_reset_mid_mul();
`else
      test_mul_disabled();
`endif
      test_random();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_results: %0d expected results never produced", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered successor to the processor's combinational ALU. Keeps the existing 4-bit opcode map for add, sub, slt and logic operations, and adds barrel shifts and an iterative unsigned multiply with a high result word. Completion is reported through a start/busy/done handshake. Sits in the execute stage; the control FSM stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width. Power of two, ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Clock and reset are fixed as stated.
- `start` in 1: request. Sampled only when `busy`=0.
- `alu_op` in 4: operation code. Sampled with `start`.
- `a` in WIDTH: operand A. Sampled with `start`.
- `b` in WIDTH: operand B. Sampled with `start`.
- `result` out WIDTH: low result word. Held until the next completion.
- `result_hi` out WIDTH: high multiply word. Zero for every other op.
- `zero` out 1: `result`==0. Registered with `result`.
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse when `result` updates.

## Operation
- Opcodes:
  - 0000 add: A+B.
  - 0010 sub: A−B.
  - 1010 slt: bit 0 = bit WIDTH−1 of (A−B), upper bits 0.
  - 0100 and.
  - 0101 or.
  - 0110 xor.
  - 0111 nor.
  - 1100 sll: A << `b[SHW-1:0]`.
  - 1101 srl: logical right shift of A.
  - 1110 sra: arithmetic right shift of A.
  - 1000 multu: {`result_hi`,`result`} = A×B, unsigned.
- Undefined codes (0001, 0011, 1001, 1011, 1111): `result`=0, `result_hi`=0, `zero`=1, single-cycle.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow or carry output.
  - slt does no overflow correction.
  - A shift amount of 0 returns A unchanged.
- States:
  - IDLE: `start`=1 with a single-cycle op registers the outputs, pulses `done`, and stays in IDLE. `start`=1 with multu loads the multiplicand, the multiplier and a counter of WIDTH, then goes to MUL.
  - MUL: one shift-add step per cycle with the counter decrementing. At counter=1 the last step writes `result`/`result_hi`/`zero`, pulses `done`, and returns to IDLE.
- `start` while `busy`=1 is ignored: no queueing, no effect on the running operation.
- `a`/`b`/`alu_op` changing during MUL has no effect; operands are captured at acceptance.

## Timing
- Reset values: `result`=0, `result_hi`=0, `zero`=1, `busy`=0, `done`=0, state IDLE, counter 0.
- `reset` asserted mid-MUL aborts immediately and asynchronously to the reset values; the partial product is discarded.
- Single-cycle ops: `start` sampled at edge t, outputs valid and `done`=1 from edge t until edge t+1. Latency 1.
- Back-to-back single-cycle ops: a new op accepted in the cycle `done` is high gives another `done` at the next edge. Throughput 1 per cycle.
- multu:
  - `busy`=1 from edge t.
  - `done`=1 and `busy`=0 from edge t+WIDTH.
  - Latency WIDTH (32 cycles at the default width).
  - A new `start` is accepted at edge t+WIDTH, i.e. in the cycle `done` is high.
- `done` is never high for more than one cycle per accepted op.

## Configuration
- `MULTALU_MUL_EN` defined: MUL state, counter, and multu datapath compiled in, as above.
- Not defined: no MUL state or multiply hardware. Opcode 1000 behaves as undefined: single-cycle, `result`=0, `result_hi`=0, `zero`=1. `busy` is tied to 0.

## Test plan
- Add/sub/zero: add a=5, b=7 → `result`=12, `zero`=0, `done` one cycle after start. Sub a=7, b=7 → `result`=0, `zero`=1.
- slt and logic: slt a=3, b=5 → 1. slt a=0xFFFFFFFF, b=1 → 1. nor a=0, b=0 → 0xFFFFFFFF. xor a=0xF0F0F0F0, b=0xFFFF0000 → 0x0F0FF0F0.
- Shifts with b=4 and a=0x80000000: sra → 0xF8000000, srl → 0x08000000. sll a=1, b=31 → 0x80000000. sll with b=0 → a unchanged.
- multu a=0xFFFFFFFF, b=2 (macro on):
  - `result_hi`=1, `result`=0xFFFFFFFE.
  - `done` exactly 32 cycles after start; `busy` high for 32 cycles.
  - A second `start` (add 1+1) at cycle 5 is ignored.
  - A `start` in the `done` cycle is accepted.
- Reset mid-multiply: assert `reset` at cycle 10 of multu → all outputs return to reset values at once. Afterwards, add a=2, b=3 → 5 with latency 1.
- Macro off: op 1000 with a=3, b=4 → `result`=0, `result_hi`=0, `zero`=1, `done` after 1 cycle, `busy` never asserted.
